// File: rtl/jelly2_texture_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// jelly2_texture_cache_mem_arbiter
//
// Shares the single port of the texture cache memory between lookup reads
// and line refill writes. A multi-beat fill burst locks the table entry it is
// writing. Reads may use the port in the gaps between fill beats, but not a
// read that targets the locked entry. Reads are kept from starving a waiting
// fill beat by a run counter: after READ_RUN_MAX consecutive read grants with
// a fill beat pending, the fill beat wins.
//
// One registered output stage drives the cache memory slave port.
//
// Ports
//   reset, clk          synchronous active-high reset, clock
//   busy                fill locked, output valid, or any input valid
//   s_fill_*            fill write beats (tbl/pix address, data, last, valid/ready)
//   s_rd_*              lookup reads (user, last, tbl/pix address, strb, valid/ready)
//   m_user              {fill_flag, read user}; fill_flag=1 marks a write beat
//   m_last, m_strb      read: passed through; fill: 0
//   m_we                fill: all ones; read: 0
//   m_wdata             fill data; read: 0
//   m_tbl_addr/pix_addr selected address
//   m_valid/m_ready     output handshake
// ---------------------------------------------------------------------------
module jelly2_texture_cache_mem_arbiter #(
  parameter int USER_WIDTH           = 1,
  parameter int COMPONENT_NUM        = 1,
  parameter int COMPONENT_DATA_WIDTH = 24,
  parameter int TBL_ADDR_WIDTH       = 6,
  parameter int PIX_ADDR_WIDTH       = 4,
  parameter int S_DATA_SIZE          = 1,
  parameter int READ_RUN_MAX         = 4,
  localparam int DATA_WIDTH          = (COMPONENT_NUM * COMPONENT_DATA_WIDTH) << S_DATA_SIZE
) (
  input  logic                        reset,
  input  logic                        clk,
  output logic                        busy,

  input  logic [TBL_ADDR_WIDTH-1:0]   s_fill_tbl_addr,
  input  logic [PIX_ADDR_WIDTH-1:0]   s_fill_pix_addr,
  input  logic [DATA_WIDTH-1:0]       s_fill_wdata,
  input  logic                        s_fill_last,
  input  logic                        s_fill_valid,
  output logic                        s_fill_ready,

  input  logic [USER_WIDTH-1:0]       s_rd_user,
  input  logic                        s_rd_last,
  input  logic [TBL_ADDR_WIDTH-1:0]   s_rd_tbl_addr,
  input  logic [PIX_ADDR_WIDTH-1:0]   s_rd_pix_addr,
  input  logic                        s_rd_strb,
  input  logic                        s_rd_valid,
  output logic                        s_rd_ready,

  output logic [USER_WIDTH:0]         m_user,
  output logic                        m_last,
  output logic                        m_strb,
  output logic [COMPONENT_NUM-1:0]    m_we,
  output logic [DATA_WIDTH-1:0]       m_wdata,
  output logic [TBL_ADDR_WIDTH-1:0]   m_tbl_addr,
  output logic [PIX_ADDR_WIDTH-1:0]   m_pix_addr,
  output logic                        m_valid,
  input  logic                        m_ready
);

  localparam int RUN_W = $clog2(READ_RUN_MAX + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t                       r_state;
  logic [TBL_ADDR_WIDTH-1:0]    r_lock_tbl;
  logic [RUN_W-1:0]             r_run_cnt;

  logic [USER_WIDTH:0]          r_m_user;
  logic                         r_m_last;
  logic                         r_m_strb;
  logic [COMPONENT_NUM-1:0]     r_m_we;
  logic [DATA_WIDTH-1:0]        r_m_wdata;
  logic [TBL_ADDR_WIDTH-1:0]    r_m_tbl_addr;
  logic [PIX_ADDR_WIDTH-1:0]    r_m_pix_addr;
  logic                         r_m_valid;

  logic                         w_adv;
  logic                         w_lock;
  logic                         w_hazard;
  logic                         w_run_full;
  logic                         w_grant_fill;
  logic                         w_grant_rd;
  logic                         w_take_fill;
  logic                         w_take_rd;

  // Grant decision (combinational, feeds the output register stage)
  assign w_adv      = !r_m_valid || m_ready;
  assign w_lock     = (r_state == ST_FILL);
  assign w_hazard   = w_lock && (s_rd_tbl_addr == r_lock_tbl);
  assign w_run_full = (r_run_cnt == RUN_W'(READ_RUN_MAX));

  // The two grants are mutually exclusive: with both sides valid the fill
  // wins exactly when the read run is exhausted or the read hits the locked
  // entry. A hazarding read with no fill pending gets nothing, so reads are
  // never reordered around it.
  assign w_grant_fill = s_fill_valid && (!s_rd_valid || w_run_full || w_hazard);
  assign w_grant_rd   = s_rd_valid && !w_hazard && !(s_fill_valid && w_run_full);

  // Handshakes are suppressed during reset so no beat is accepted and lost.
  assign w_take_fill = !reset && w_adv && w_grant_fill;
  assign w_take_rd   = !reset && w_adv && w_grant_rd;

  assign s_fill_ready = w_take_fill;
  assign s_rd_ready   = w_take_rd;

  assign busy = w_lock || r_m_valid || s_fill_valid || s_rd_valid;

  // Output register stage, lock FSM and read-run counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lock_tbl   <= '0;
      r_run_cnt    <= '0;
      r_m_user     <= '0;
      r_m_last     <= 1'b0;
      r_m_strb     <= 1'b0;
      r_m_we       <= '0;
      r_m_wdata    <= '0;
      r_m_tbl_addr <= '0;
      r_m_pix_addr <= '0;
      r_m_valid    <= 1'b0;
    end else begin
      // A single-beat burst (last on the first beat) never takes the lock.
      if (w_take_fill) begin
        case (r_state)
          ST_IDLE: begin
            if (!s_fill_last) begin
              r_state    <= ST_FILL;
              r_lock_tbl <= s_fill_tbl_addr;
            end
          end
          ST_FILL: begin
            if (s_fill_last) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      // Counts reads that overtook a waiting fill beat.
      if (!s_fill_valid || w_take_fill) begin
        r_run_cnt <= '0;
      end else if (w_take_rd && !w_run_full) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end

      if (w_adv) begin
        r_m_valid <= w_take_fill || w_take_rd;
        if (w_take_fill) begin
          r_m_user     <= {1'b1, {USER_WIDTH{1'b0}}};
          r_m_last     <= 1'b0;
          r_m_strb     <= 1'b0;
          r_m_we       <= '1;
          r_m_wdata    <= s_fill_wdata;
          r_m_tbl_addr <= s_fill_tbl_addr;
          r_m_pix_addr <= s_fill_pix_addr;
        end else if (w_take_rd) begin
          r_m_user     <= {1'b0, s_rd_user};
          r_m_last     <= s_rd_last;
          r_m_strb     <= s_rd_strb;
          r_m_we       <= '0;
          r_m_wdata    <= '0;
          r_m_tbl_addr <= s_rd_tbl_addr;
          r_m_pix_addr <= s_rd_pix_addr;
        end
      end
    end
  end

  assign m_user     = r_m_user;
  assign m_last     = r_m_last;
  assign m_strb     = r_m_strb;
  assign m_we       = r_m_we;
  assign m_wdata    = r_m_wdata;
  assign m_tbl_addr = r_m_tbl_addr;
  assign m_pix_addr = r_m_pix_addr;
  assign m_valid    = r_m_valid;

endmodule
